// File: rtl/sonic_v1_15_eth_10g_lc_stream_arbiter.sv
// sonic_v1_15_eth_10g_lc_stream_arbiter
// Purpose     : packet-atomic round-robin merge of two beat streams onto one output stream.
// Latency     : 1 cycle from input accept to out_*; one idle arbitration cycle per packet.
// Backpressure: out_ready low with a full output register drops the granted input's ready.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   in0_data/valid/endofpacket/ready     requester 0 beat stream
//   in1_data/valid/endofpacket/ready     requester 1 beat stream
//   out_data/valid/endofpacket/channel   registered merged stream, out_channel = source
//   out_ready                            downstream accept (ready latency 0)
//   pkt_cnt0, pkt_cnt1                   wrapping counts of packets accepted per input
module sonic_v1_15_eth_10g_lc_stream_arbiter #(
  parameter int DATA_W = 72,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  input  logic              in0_endofpacket,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  input  logic              in1_endofpacket,
  output logic              in1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_endofpacket,
  output logic              out_channel,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0] state;
  logic       last_grant;   // input that finished the most recent packet
  logic       out_free;     // output register can take a beat this cycle
  logic       acc0;
  logic       acc1;

  // Ready depends only on state and the output register, never on in*_valid,
  // so no valid-to-output combinational path exists.
  assign out_free  = !out_valid || out_ready;
  assign in0_ready = (state == GRANT0) && out_free;
  assign in1_ready = (state == GRANT1) && out_free;
  assign acc0      = in0_valid && in0_ready;
  assign acc1      = in1_valid && in1_ready;

  // Grant is held until the owner's endofpacket beat is accepted, then the
  // FSM returns to IDLE for one arbitration cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in0_valid && in1_valid) begin
            state <= last_grant ? GRANT0 : GRANT1;
          end else if (in0_valid) begin
            state <= GRANT0;
          end else if (in1_valid) begin
            state <= GRANT1;
          end
        end
        GRANT0: begin
          if (acc0 && in0_endofpacket) begin
            state      <= IDLE;
            last_grant <= 1'b0;
          end
        end
        GRANT1: begin
          if (acc1 && in1_endofpacket) begin
            state      <= IDLE;
            last_grant <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single output register; payload is left untouched when a beat drains so
  // fields stay stable whenever out_valid is held under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_endofpacket <= 1'b0;
      out_channel     <= 1'b0;
    end else if (acc0 || acc1) begin
      out_valid       <= 1'b1;
      out_data        <= acc1 ? in1_data : in0_data;
      out_endofpacket <= acc1 ? in1_endofpacket : in0_endofpacket;
      out_channel     <= acc1;
    end else if (out_ready) begin
      out_valid       <= 1'b0;
    end
  end

  // Counted at input acceptance of the last beat; wraps silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (acc0 && in0_endofpacket) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (acc1 && in1_endofpacket) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sonic_v1_15_eth_10g_lc_stream_arbiter.sv
// tb_sonic_v1_15_eth_10g_lc_stream_arbiter
// Purpose     : self-checking bench for the two-input packet arbiter.
// Latency     : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: out_ready is driven from vectors, hand sequences and random draws.
module tb_sonic_v1_15_eth_10g_lc_stream_arbiter;

  localparam int DATA_W = 72;
  // Narrow counter so a full wrap needs only a few thousand packets.
  localparam int CNT_W  = 12;
  localparam int WRAP   = 1 << CNT_W;

  logic              clk;
  logic              reset_n;
  logic [DATA_W-1:0] in0_data;
  logic              in0_valid;
  logic              in0_endofpacket;
  logic              in0_ready;
  logic [DATA_W-1:0] in1_data;
  logic              in1_valid;
  logic              in1_endofpacket;
  logic              in1_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_endofpacket;
  logic              out_channel;
  logic              out_ready;
  logic [CNT_W-1:0]  pkt_cnt0;
  logic [CNT_W-1:0]  pkt_cnt1;

  sonic_v1_15_eth_10g_lc_stream_arbiter #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in0_data       (in0_data),
    .in0_valid      (in0_valid),
    .in0_endofpacket(in0_endofpacket),
    .in0_ready      (in0_ready),
    .in1_data       (in1_data),
    .in1_valid      (in1_valid),
    .in1_endofpacket(in1_endofpacket),
    .in1_ready      (in1_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_endofpacket(out_endofpacket),
    .out_channel    (out_channel),
    .out_ready      (out_ready),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkc(input string nm, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n         = 1'b0;
    in0_valid       = 1'b0;
    in1_valid       = 1'b0;
    in0_endofpacket = 1'b0;
    in1_endofpacket = 1'b0;
    in0_data        = '0;
    in1_data        = '0;
    out_ready       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DATA_W-1:0];
  endfunction

  // in  = {rst, v0, e0, v1, e1, out_ready}
  // exp = {in0_ready, in1_ready, out_valid, out_endofpacket, out_channel}
  // od  = expected out_data (in0 drives 0x100+row, in1 drives 0x200+row)
  typedef struct packed {
    logic [5:0]  in;
    logic [4:0]  exp;
    logic [11:0] od;
    logic [3:0]  c0;
    logic [3:0]  c1;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              e;
    logic              ch;
  } beat_t;

  vec_t  tbl[32];
  beat_t q[$];
  beat_t b;
  int    owner;
  int    last_done;
  int    cnt_m[2];
  logic  er0, er1, t_rst, t_ordy;
  logic  a0, a1;
  int    acc;
  int    guard;
  logic [DATA_W-1:0] keep0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached, limit 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      // in0 3-beat packet, out_ready high
      '{6'b010001, 5'b00000, 12'h000, 4'd0, 4'd0},
      '{6'b010001, 5'b10000, 12'h000, 4'd0, 4'd0},
      '{6'b010001, 5'b10100, 12'h101, 4'd0, 4'd0},
      '{6'b011001, 5'b10100, 12'h102, 4'd0, 4'd0},
      '{6'b000001, 5'b00110, 12'h103, 4'd1, 4'd0},
      '{6'b000001, 5'b00000, 12'h000, 4'd1, 4'd0},
      // reset, then simultaneous 2-beat requests: in0 first, bubble, in1
      '{6'b100001, 5'b00000, 12'h000, 4'd0, 4'd0},
      '{6'b010101, 5'b00000, 12'h000, 4'd0, 4'd0},
      '{6'b010101, 5'b10000, 12'h000, 4'd0, 4'd0},
      '{6'b011101, 5'b10100, 12'h108, 4'd0, 4'd0},
      '{6'b000101, 5'b00110, 12'h109, 4'd1, 4'd0},
      '{6'b000101, 5'b01000, 12'h000, 4'd1, 4'd0},
      '{6'b000111, 5'b01101, 12'h20B, 4'd1, 4'd0},
      '{6'b000001, 5'b00111, 12'h20C, 4'd1, 4'd1},
      '{6'b000001, 5'b00000, 12'h000, 4'd1, 4'd1},
      // in1 mid-packet while in0 requests
      '{6'b000101, 5'b00000, 12'h000, 4'd1, 4'd1},
      '{6'b000101, 5'b01000, 12'h000, 4'd1, 4'd1},
      '{6'b010101, 5'b01101, 12'h210, 4'd1, 4'd1},
      '{6'b010111, 5'b01101, 12'h211, 4'd1, 4'd1},
      '{6'b010001, 5'b00111, 12'h212, 4'd1, 4'd2},
      '{6'b011001, 5'b10000, 12'h000, 4'd1, 4'd2},
      '{6'b000001, 5'b00110, 12'h114, 4'd2, 4'd2},
      '{6'b000001, 5'b00000, 12'h000, 4'd2, 4'd2},
      // out_ready low for 4 cycles mid-packet
      '{6'b010001, 5'b00000, 12'h000, 4'd2, 4'd2},
      '{6'b010001, 5'b10000, 12'h000, 4'd2, 4'd2},
      '{6'b010000, 5'b00100, 12'h118, 4'd2, 4'd2},
      '{6'b010000, 5'b00100, 12'h118, 4'd2, 4'd2},
      '{6'b010000, 5'b00100, 12'h118, 4'd2, 4'd2},
      '{6'b010000, 5'b00100, 12'h118, 4'd2, 4'd2},
      '{6'b011001, 5'b10100, 12'h118, 4'd2, 4'd2},
      '{6'b000001, 5'b00110, 12'h11D, 4'd3, 4'd2},
      '{6'b000001, 5'b00000, 12'h000, 4'd3, 4'd2}
    };

    reset_n = 1'b0;
    do_reset();

    // ---------------- table-driven vectors ----------------
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      #1;
      {t_rst, in0_valid, in0_endofpacket, in1_valid, in1_endofpacket, t_ordy} = tbl[k].in;
      reset_n   = !t_rst;
      out_ready = t_ordy;
      in0_data  = DATA_W'(256 + k);
      in1_data  = DATA_W'(512 + k);
      @(negedge clk);
      chk1($sformatf("row%0d in0_ready", k), in0_ready, tbl[k].exp[4]);
      chk1($sformatf("row%0d in1_ready", k), in1_ready, tbl[k].exp[3]);
      chk1($sformatf("row%0d out_valid", k), out_valid, tbl[k].exp[2]);
      if (tbl[k].exp[2] || t_rst) begin
        chk1($sformatf("row%0d out_eop", k), out_endofpacket, tbl[k].exp[1]);
        chk1($sformatf("row%0d out_channel", k), out_channel, tbl[k].exp[0]);
        chkd($sformatf("row%0d out_data", k), out_data, DATA_W'(tbl[k].od));
      end
      chkc($sformatf("row%0d pkt_cnt0", k), pkt_cnt0, CNT_W'(tbl[k].c0));
      chkc($sformatf("row%0d pkt_cnt1", k), pkt_cnt1, CNT_W'(tbl[k].c1));
    end

    // ---------------- random stimulus vs reference model ----------------
    do_reset();
    owner     = -1;
    last_done = 1;
    cnt_m[0]  = 0;
    cnt_m[1]  = 0;
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      in0_valid       = ($urandom_range(9, 0) < 7);
      in0_endofpacket = ($urandom_range(2, 0) == 0);
      in0_data        = rnd_data();
      in1_valid       = ($urandom_range(9, 0) < 7);
      in1_endofpacket = ($urandom_range(2, 0) == 0);
      in1_data        = rnd_data();
      out_ready       = ($urandom_range(3, 0) != 0);
      @(negedge clk);
      // An owner may push a beat only when the pending output slot is empty or leaving.
      er0 = (owner == 0) && (q.size() == 0 || out_ready);
      er1 = (owner == 1) && (q.size() == 0 || out_ready);
      chk1("rnd in0_ready", in0_ready, er0);
      chk1("rnd in1_ready", in1_ready, er1);
      chk1("rnd out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chkd("rnd out_data", out_data, q[0].d);
        chk1("rnd out_eop", out_endofpacket, q[0].e);
        chk1("rnd out_channel", out_channel, q[0].ch);
      end
      chkc("rnd pkt_cnt0", pkt_cnt0, CNT_W'(cnt_m[0]));
      chkc("rnd pkt_cnt1", pkt_cnt1, CNT_W'(cnt_m[1]));
      // what happens at the coming rising edge
      a0 = er0 && in0_valid;
      a1 = er1 && in1_valid;
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (a0) begin
        b.d = in0_data; b.e = in0_endofpacket; b.ch = 1'b0;
        q.push_back(b);
      end
      if (a1) begin
        b.d = in1_data; b.e = in1_endofpacket; b.ch = 1'b1;
        q.push_back(b);
      end
      if (owner < 0) begin
        // ties go to the input that did not finish the last packet
        if (in0_valid && in1_valid) owner = (last_done == 0) ? 1 : 0;
        else if (in0_valid)         owner = 0;
        else if (in1_valid)         owner = 1;
      end else if ((owner == 0 && a0 && in0_endofpacket) ||
                   (owner == 1 && a1 && in1_endofpacket)) begin
        cnt_m[owner] = (cnt_m[owner] + 1) % WRAP;
        last_done    = owner;
        owner        = -1;
      end
    end

    // ---------------- reset during beat 2 of a 4-beat in0 packet ----------------
    do_reset();
    @(posedge clk); #1;
    in1_valid = 1'b1; in1_endofpacket = 1'b1; in1_data = DATA_W'(72'h55);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("mid in1 single-beat ready", in1_ready, 1'b1);
    @(posedge clk); #1;
    in1_valid = 1'b0;
    in0_valid = 1'b1; in0_endofpacket = 1'b0; in0_data = DATA_W'(72'hA0);
    @(negedge clk);
    chkc("mid pkt_cnt1 before reset", pkt_cnt1, CNT_W'(1));
    chk1("mid idle bubble in0_ready", in0_ready, 1'b0);
    @(posedge clk); #1;
    in0_data = DATA_W'(72'hA1);
    @(negedge clk);
    chk1("mid beat1 in0_ready", in0_ready, 1'b1);
    @(posedge clk); #1;
    in0_data = DATA_W'(72'hA2);
    @(negedge clk);
    chkd("mid beat1 out_data", out_data, DATA_W'(72'hA1));
    reset_n = 1'b0;
    #1;
    chk1("mid reset out_valid", out_valid, 1'b0);
    chk1("mid reset in0_ready", in0_ready, 1'b0);
    chkd("mid reset out_data", out_data, '0);
    chkc("mid reset pkt_cnt1", pkt_cnt1, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    in0_valid = 1'b1; in0_endofpacket = 1'b1; in0_data = DATA_W'(72'hB0);
    in1_valid = 1'b1; in1_endofpacket = 1'b1; in1_data = DATA_W'(72'hC0);
    @(negedge clk);
    chk1("post reset idle in0_ready", in0_ready, 1'b0);
    chk1("post reset out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("post reset tie in0_ready", in0_ready, 1'b1);
    chk1("post reset tie in1_ready", in1_ready, 1'b0);
    @(posedge clk); #1;
    in0_valid = 1'b0;
    @(negedge clk);
    chkd("post reset out_data", out_data, DATA_W'(72'hB0));
    chk1("post reset out_channel", out_channel, 1'b0);
    chkc("post reset pkt_cnt0", pkt_cnt0, CNT_W'(1));
    @(posedge clk); #1;
    @(negedge clk);
    chk1("post reset in1 granted", in1_ready, 1'b1);
    @(posedge clk); #1;
    in1_valid = 1'b0;

    // ---------------- pkt_cnt0 wrap ----------------
    do_reset();
    in0_valid = 1'b1; in0_endofpacket = 1'b1; keep0 = rnd_data(); in0_data = keep0;
    acc   = 0;
    guard = 0;
    while (acc < WRAP - 1 && guard < 4 * WRAP) begin
      @(negedge clk);
      guard++;
      if (in0_ready) acc++;
    end
    @(posedge clk); #1;
    in0_valid = 1'b0;
    @(negedge clk);
    chk1("wrap preset within budget", acc == WRAP - 1, 1'b1);
    chkc("wrap preset pkt_cnt0", pkt_cnt0, '1);
    @(posedge clk); #1;
    in0_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!in0_ready && guard < 10);
    @(posedge clk); #1;
    in0_valid = 1'b0;
    @(negedge clk);
    chk1("wrap final accept seen", guard < 10, 1'b1);
    chkc("wrap pkt_cnt0", pkt_cnt0, '0);
    chkc("wrap pkt_cnt1", pkt_cnt1, '0);
    chkd("wrap out_data", out_data, keep0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sonic_v1_15_eth_10g_lc_stream_arbiter.md
SONIC_V1_15_ETH_10G_LC_STREAM_ARBITER -- requirements
Module: sonic_v1_15_eth_10g_lc_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 72, beat payload width.
REQ-002 SHALL have parameter CNT_W, default 16, per-input packet counter width.
REQ-003 SHALL have the following ports, one per line:
- clk  input  1  single clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in0_data  input  DATA_W  requester 0 beat payload.
- in0_valid  input  1  requester 0 beat valid.
- in0_endofpacket  input  1  requester 0 last beat of packet.
- in0_ready  output  1  requester 0 beat accepted when high with in0_valid.
- in1_data  input  DATA_W  requester 1 beat payload.
- in1_valid  input  1  requester 1 beat valid.
- in1_endofpacket  input  1  requester 1 last beat of packet.
- in1_ready  output  1  requester 1 accept.
- out_data  output  DATA_W  shared splitter-path payload.
- out_valid  output  1  out_data valid.
- out_endofpacket  output  1  last beat on output.
- out_channel  output  1  source of current output beat (0/1).
- out_ready  input  1  downstream accept, ready latency 0.
- pkt_cnt0  output  CNT_W  completed packets forwarded from in0.
- pkt_cnt1  output  CNT_W  completed packets forwarded from in1.

Function
REQ-004 FSM states SHALL be IDLE, GRANT0, GRANT1; encoding free.
REQ-005 Request for input i SHALL be ini_valid; startofpacket is not checked.
REQ-006 In IDLE with exactly one request, FSM SHALL go to that input's GRANT state next cycle.
REQ-007 In IDLE with both requesting, FSM SHALL grant the input not equal to last_grant (round robin); after reset last_grant = 1, so in0 wins first tie.
REQ-008 In IDLE, both in0_ready and in1_ready SHALL be 0 (one-cycle arbitration bubble per packet).
REQ-009 In GRANTi, ini_ready SHALL equal (!out_valid || out_ready); the other input's ready SHALL be 0.
REQ-010 Output stage SHALL be a single register: beat accepted in cycle N appears on out_* in cycle N+1 (latency 1).
REQ-011 Output register SHALL load on an accepted input beat; otherwise, if out_ready is high, out_valid SHALL clear; otherwise hold.
REQ-012 With out_ready held high and valid input, throughput SHALL be one beat per cycle after the bubble.
REQ-013 out_data, out_endofpacket, out_channel SHALL be stable while out_valid=1 and out_ready=0.
REQ-014 Accepting a beat with endofpacket=1 in GRANTi SHALL move FSM to IDLE next cycle and set last_grant = i.
REQ-015 A single-beat packet (valid with eop on first beat) SHALL be handled as in REQ-014.
REQ-016 Grant SHALL never change mid-packet regardless of the other input's requests.
REQ-017 pkt_cntI SHALL increment by 1 on each accepted eop beat from input i; wrap from all-ones to 0 with no saturation or flag.
REQ-018 Counters SHALL increment at input acceptance, not at output drain.
REQ-019 No combinational path SHALL exist from in*_valid to out_*; out_ready to in*_ready combinational path is permitted.

Reset
REQ-020 While reset_n=0: FSM=IDLE, last_grant=1, out_valid=0, out_endofpacket=0, out_channel=0, out_data=0, pkt_cnt0=pkt_cnt1=0, in0_ready=in1_ready=0.
REQ-021 Reset asserted mid-packet SHALL discard the in-flight output beat and the partial packet; no counter increment for it.
REQ-022 After deassertion, first grant SHALL be available one cycle after first valid request.

Verification
REQ-023 Bench SHALL cover, minimum:
- in0 sends 3-beat packet, out_ready=1 -> in0_ready high cycles 1..3 after request seen, out_valid cycles 2..4, out_channel=0, pkt_cnt0=1.
- both inputs request simultaneously after reset, 2-beat packets each -> in0 packet fully out first, IDLE bubble, then in1; pkt_cnt0=1, pkt_cnt1=1.
- in1 mid-packet, in0 asserts valid -> no in0_ready until in1 eop accepted; out_channel stays 1 across in1 packet.
- out_ready=0 for 4 cycles during packet -> out_data/out_valid held, ini_ready=0, no beat lost or duplicated; resume on out_ready=1.
- pkt_cnt0 preset by 65535 single-beat packets, one more -> pkt_cnt0=0.
- reset_n pulsed low during beat 2 of 4-beat in0 packet -> out_valid=0 immediately, counters 0, next tie grants in0.
